// File: rtl/sprite_motion_unit.sv
// Per-sprite motion engine: holds position/velocity, steps position every UPDATE_PERIOD cycles.
// Latency: writes land on the next edge; step and position update share an edge; within_screen lags x/y by one cycle.
// Backpressure: none; strobes are accepted unconditionally every cycle, with write_xy overriding a coincident tick.
module sprite_motion_unit #(
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 10,
  parameter int DXY_WIDTH     = 3,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int UPDATE_PERIOD = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sprite_write_xy,
  input  logic                 sprite_write_dxy,
  input  logic                 sprite_enable_update,
  input  logic [X_WIDTH-1:0]   x0,
  input  logic [Y_WIDTH-1:0]   y0,
  input  logic [DXY_WIDTH-1:0] dx0,
  input  logic [DXY_WIDTH-1:0] dy0,
  output logic [X_WIDTH-1:0]   x,
  output logic [Y_WIDTH-1:0]   y,
  output logic                 within_screen,
  output logic                 step
);

  // Counter is wide enough to hold UPDATE_PERIOD-1; period must be at least 2.
  localparam int CNT_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_PERIOD - 1);

  // Largest top-left coordinate that still keeps the whole sprite visible.
  localparam logic [X_WIDTH-1:0] X_LIMIT = X_WIDTH'(SCREEN_WIDTH - SPRITE_WIDTH);
  localparam logic [Y_WIDTH-1:0] Y_LIMIT = Y_WIDTH'(SCREEN_HEIGHT - SPRITE_HEIGHT);

  logic [CNT_W-1:0]     cnt;
  logic [DXY_WIDTH-1:0] dx;
  logic [DXY_WIDTH-1:0] dy;
  logic                 tick;
  logic [X_WIDTH-1:0]   dx_ext;
  logic [Y_WIDTH-1:0]   dy_ext;

  // Tick fires on the last count of a period; a position load in the same cycle cancels it.
  always_comb begin
    tick   = sprite_enable_update && !sprite_write_xy && (cnt == CNT_LAST);
    dx_ext = {{(X_WIDTH - DXY_WIDTH){dx[DXY_WIDTH-1]}}, dx};
    dy_ext = {{(Y_WIDTH - DXY_WIDTH){dy[DXY_WIDTH-1]}}, dy};
  end

  // Period counter: idles at zero while disabled or reloaded, so every (re)start waits a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!sprite_enable_update || sprite_write_xy) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Position: explicit load beats motion; motion wraps modulo the register width.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (sprite_write_xy) begin
      x <= x0;
      y <= y0;
    end else if (tick) begin
      x <= x + dx_ext;
      y <= y + dy_ext;
    end
  end

  // Velocity: a load coinciding with a tick takes effect from the following step.
  always_ff @(posedge clk) begin
    if (rst) begin
      dx <= '0;
      dy <= '0;
    end else if (sprite_write_dxy) begin
      dx <= dx0;
      dy <= dy0;
    end
  end

  // Status: step marks a motion update; visibility is judged from the registered position.
  always_ff @(posedge clk) begin
    if (rst) begin
      step          <= 1'b0;
      within_screen <= 1'b1;
    end else begin
      step          <= tick;
      within_screen <= (x <= X_LIMIT) && (y <= Y_LIMIT);
    end
  end

endmodule

// File: tb/tb_sprite_motion_unit.sv
// Bench for sprite_motion_unit with a short update period, directed scenarios plus random traffic.
// Reference model tracks enabled run length and applies motion rules with plain integer arithmetic.
module tb_sprite_motion_unit;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wxy, wdxy, en;
  logic [9:0] x0, y0;
  logic [2:0] dx0, dy0;
  logic [9:0] x, y;
  logic       within_screen, step;

  int total = 0;
  int bad   = 0;

  // reference model state
  int mx, my, mdx, mdy, run;
  bit mstep, mwithin;

  sprite_motion_unit #(
    .X_WIDTH(10), .Y_WIDTH(10), .DXY_WIDTH(3),
    .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480),
    .SPRITE_WIDTH(8), .SPRITE_HEIGHT(8),
    .UPDATE_PERIOD(P)
  ) dut (
    .clk(clk), .rst(rst),
    .sprite_write_xy(wxy), .sprite_write_dxy(wdxy), .sprite_enable_update(en),
    .x0(x0), .y0(y0), .dx0(dx0), .dy0(dy0),
    .x(x), .y(y), .within_screen(within_screen), .step(step)
  );

  always #5 clk = ~clk;

  // One clock edge with the currently driven inputs; the model advances at the same edge.
  task automatic cyc(input bit r, input bit w_xy, input bit w_dxy, input bit e);
    bit t;
    rst = r; wxy = w_xy; wdxy = w_dxy; en = e;
    @(posedge clk);
    if (r) begin
      mx = 0; my = 0; mdx = 0; mdy = 0; run = 0; mstep = 0; mwithin = 1;
    end else begin
      mwithin = (mx <= 640 - 8) && (my <= 480 - 8);
      t = 0;
      if (!e || w_xy) run = 0;
      else begin
        run++;
        t = (run % P) == 0;
      end
      if (w_xy) begin
        mx = int'(x0); my = int'(y0);
      end else if (t) begin
        mx = (mx + mdx) & 1023;
        my = (my + mdy) & 1023;
      end
      if (w_dxy) begin
        mdx = int'($signed(dx0)); mdy = int'($signed(dy0));
      end
      mstep = t;
    end
    #1;
  endtask

  task automatic test_reset;
    x0 = 0; y0 = 0; dx0 = 0; dy0 = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    total++; if (x !== 10'd0 || y !== 10'd0) begin bad++; $display("FAIL reset_xy got %0d/%0d want 0/0", x, y); end
    total++; if (step !== 1'b0) begin bad++; $display("FAIL reset_step got %b want 0", step); end
    total++; if (within_screen !== 1'b1) begin bad++; $display("FAIL reset_within got %b want 1", within_screen); end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_basic_motion;
    int ex;
    x0 = 100; y0 = 50; dx0 = 3'd2; dy0 = 3'b111;
    cyc(0, 1, 1, 0);
    for (int c = 1; c <= 12; c++) begin
      cyc(0, 0, 0, 1);
      ex = 100 + 2 * (c / P);
      total++; if (step !== ((c % P) == 0)) begin bad++; $display("FAIL basic_step c=%0d got %b want %b", c, step, (c % P) == 0); end
      total++; if (x !== 10'(ex) || y !== 10'(50 - c / P)) begin bad++; $display("FAIL basic_xy c=%0d got %0d/%0d want %0d/%0d", c, x, y, ex, 50 - c / P); end
      total++; if (within_screen !== 1'b1) begin bad++; $display("FAIL basic_within c=%0d got %b want 1", c, within_screen); end
    end
    total++; if (x !== 10'd106 || y !== 10'd47) begin bad++; $display("FAIL basic_final got %0d/%0d want 106/47", x, y); end
  endtask

  task automatic test_enable_toggle;
    logic [9:0] hold;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    hold = x;
    for (int c = 0; c < 5; c++) begin
      cyc(0, 0, 0, 0);
      total++; if (step !== 1'b0 || x !== hold) begin bad++; $display("FAIL toggle_low c=%0d got step=%b x=%0d want 0/%0d", c, step, x, hold); end
    end
    for (int c = 1; c <= P; c++) begin
      cyc(0, 0, 0, 1);
      total++; if (step !== (c == P)) begin bad++; $display("FAIL toggle_step c=%0d got %b want %b", c, step, c == P); end
    end
    total++; if (x !== hold + 10'd2) begin bad++; $display("FAIL toggle_x got %0d want %0d", x, hold + 10'd2); end
  endtask

  task automatic test_write_on_tick;
    for (int c = 0; c < P - 1; c++) cyc(0, 0, 0, 1);
    x0 = 10; y0 = y;
    cyc(0, 1, 0, 1);
    total++; if (x !== 10'd10 || step !== 1'b0) begin bad++; $display("FAIL wtick_load got x=%0d step=%b want 10/0", x, step); end
    for (int c = 1; c <= P; c++) begin
      cyc(0, 0, 0, 1);
      total++; if (step !== (c == P)) begin bad++; $display("FAIL wtick_step c=%0d got %b want %b", c, step, c == P); end
    end
    total++; if (x !== 10'd12) begin bad++; $display("FAIL wtick_x got %0d want 12", x); end
  endtask

  task automatic test_edge_exit;
    x0 = 632; y0 = 100; dx0 = 3'd1; dy0 = 3'd0;
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    total++; if (within_screen !== 1'b1) begin bad++; $display("FAIL edge_in got %b want 1", within_screen); end
    for (int c = 0; c < P; c++) cyc(0, 0, 0, 1);
    total++; if (x !== 10'd633 || step !== 1'b1 || within_screen !== 1'b1) begin bad++; $display("FAIL edge_step got x=%0d step=%b ws=%b want 633/1/1", x, step, within_screen); end
    cyc(0, 0, 0, 0);
    total++; if (within_screen !== 1'b0) begin bad++; $display("FAIL edge_out got %b want 0", within_screen); end
    x0 = 0; dx0 = 3'b111;
    cyc(0, 1, 1, 0);
    for (int c = 0; c < P; c++) cyc(0, 0, 0, 1);
    total++; if (x !== 10'd1023) begin bad++; $display("FAIL wrap_x got %0d want 1023", x); end
    cyc(0, 0, 0, 0);
    total++; if (within_screen !== 1'b0) begin bad++; $display("FAIL wrap_within got %b want 0", within_screen); end
  endtask

  task automatic test_dxy_on_tick;
    x0 = 200; y0 = 100; dx0 = 3'd2; dy0 = 3'd0;
    cyc(0, 1, 1, 0);
    for (int c = 0; c < P - 1; c++) cyc(0, 0, 0, 1);
    dx0 = 3'b101;
    cyc(0, 0, 1, 1);
    total++; if (x !== 10'd202 || step !== 1'b1) begin bad++; $display("FAIL dxy_old got x=%0d step=%b want 202/1", x, step); end
    for (int c = 0; c < P; c++) cyc(0, 0, 0, 1);
    total++; if (x !== 10'd199) begin bad++; $display("FAIL dxy_new got %0d want 199", x); end
  endtask

  task automatic test_reset_mid;
    x0 = 300; y0 = 200; dx0 = 3'd1; dy0 = 3'd1;
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    total++; if (x !== 10'd0 || y !== 10'd0 || step !== 1'b0 || within_screen !== 1'b1) begin
      bad++; $display("FAIL rstmid got x=%0d y=%0d step=%b ws=%b want 0/0/0/1", x, y, step, within_screen);
    end
    for (int c = 1; c <= P; c++) begin
      cyc(0, 0, 0, 1);
      total++; if (step !== (c == P)) begin bad++; $display("FAIL rstmid_step c=%0d got %b want %b", c, step, c == P); end
    end
    total++; if (x !== 10'd0) begin bad++; $display("FAIL rstmid_x got %0d want 0", x); end
  endtask

  task automatic test_random;
    bit r, a, b, e;
    for (int c = 0; c < 400; c++) begin
      x0 = 10'($urandom_range(0, 1023));
      y0 = 10'($urandom_range(0, 1023));
      dx0 = 3'($urandom);
      dy0 = 3'($urandom);
      r = ($urandom_range(0, 99) < 2);
      a = ($urandom_range(0, 99) < 6);
      b = ($urandom_range(0, 99) < 10);
      e = ($urandom_range(0, 99) < 85);
      cyc(r, a, b, e);
      total++; if (x !== 10'(mx) || y !== 10'(my) || step !== mstep || within_screen !== mwithin) begin
        bad++; $display("FAIL random c=%0d got x=%0d y=%0d step=%b ws=%b want %0d/%0d/%b/%b", c, x, y, step, within_screen, mx, my, mstep, mwithin);
      end
    end
  endtask

  initial begin
    rst = 1; wxy = 0; wdxy = 0; en = 0;
    x0 = 0; y0 = 0; dx0 = 0; dy0 = 0;
    mx = 0; my = 0; mdx = 0; mdy = 0; run = 0; mstep = 0; mwithin = 1;
    test_reset;
    test_basic_motion;
    test_enable_toggle;
    test_write_on_tick;
    test_edge_exit;
    test_dxy_on_tick;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_motion_unit.md
Name: sprite_motion_unit

Overview:
- Per-sprite motion engine; the responder end of the game master's sprite control interface.
- Consumes `*_write_xy`, `*_write_dxy` and `*_enable_update` strobes. Holds sprite position and velocity, advances position at a fixed tick rate, and reports `within_screen` back to the game master.
- One instance per target plus one for the torpedo; position outputs feed the sprite renderer and collision logic.

Parameters:
- X_WIDTH, 10: width of x position register (unsigned, modulo 2^X_WIDTH).
- Y_WIDTH, 10: width of y position register (unsigned, modulo 2^Y_WIDTH).
- DXY_WIDTH, 3: width of signed dx/dy velocity (two's complement).
- SCREEN_WIDTH, 640: visible screen width in pixels.
- SCREEN_HEIGHT, 480: visible screen height in pixels.
- SPRITE_WIDTH, 8: sprite width in pixels.
- SPRITE_HEIGHT, 8: sprite height in pixels.
- UPDATE_PERIOD, 1000000: clock cycles per motion step; legal range ≥ 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sprite_write_xy  input  1  load x/y from x0/y0 this cycle.
- sprite_write_dxy  input  1  load dx/dy from dx0/dy0 this cycle.
- sprite_enable_update  input  1  level; motion runs while high.
- x0  input  X_WIDTH  initial x.
- y0  input  Y_WIDTH  initial y.
- dx0  input  DXY_WIDTH  initial signed x velocity.
- dy0  input  DXY_WIDTH  initial signed y velocity.
- x  output  X_WIDTH  current x (registered).
- y  output  Y_WIDTH  current y (registered).
- within_screen  output  1  sprite fully on screen (registered).
- step  output  1  one-cycle pulse on each motion step.

Behaviour:
- One clock. Reset is synchronous and active-high. All state changes on posedge clk; rst has priority over every other input.
- Reset values:
  - x=0, y=0, dx=0, dy=0, tick counter=0.
  - step=0, within_screen=1.
- Tick counter (width clog2(UPDATE_PERIOD)):
  - Cleared to 0 when sprite_enable_update=0 or sprite_write_xy=1.
  - Otherwise increments. At UPDATE_PERIOD-1 it wraps to 0 and asserts internal tick.
  - First step therefore occurs exactly UPDATE_PERIOD cycles after enable rises (with no intervening write_xy).
- Write priority per cycle:
  - sprite_write_xy=1: x<=x0, y<=y0. Any tick that cycle is suppressed; no step pulse.
  - sprite_write_dxy=1: dx<=dx0, dy<=dy0. Independent of write_xy; both may fire together.
  - tick=1 and no write_xy: x<=x+sext(dx), y<=y+sext(dy), modulo register width.
    - Uses the old dx/dy if write_dxy fires the same cycle; the new velocity applies from the next step.
- step: registered. Asserted for exactly one cycle, the cycle after a position update from tick. Never asserted due to writes.
- within_screen: registered from the current x/y, so it lags x/y by one cycle.
  - Value: (x ≤ SCREEN_WIDTH−SPRITE_WIDTH) && (y ≤ SCREEN_HEIGHT−SPRITE_HEIGHT).
  - Negative wrap (e.g. x=0, dx=−1 → 1023) is reported out of screen, because the unsigned compare fails.
- No saturation or bounce: the game master restarts off-screen sprites by asserting write_xy/write_dxy.
- Deassertion of enable mid-period: position holds, counter resets. Re-enable restarts a full period.
- Reset mid-operation: all registers return to reset values on the next edge. The position is not preserved.

Test Plan:
- Reset, then bench with UPDATE_PERIOD=4:
  - write_xy with x0=100, y0=50 and write_dxy with dx0=2, dy0=−1 in the same cycle, then enable held high.
  - Required: x/y = 102/49 four cycles after enable; step pulses every 4 cycles; after 3 steps x=106, y=47; within_screen=1 throughout.
- Enable toggled low at count 2, high again 5 cycles later: no step while low; next step exactly 4 cycles after re-enable; x unchanged while low.
- write_xy (x0=10) coinciding with a tick cycle: x=10 next cycle, no step pulse, next step 4 cycles later gives x=10+dx.
- Edge exit: x=632, dx=1, enabled: within_screen=1 at x=632; x becomes 633 at a step and within_screen drops to 0 one cycle later. Left wrap: x=0, dx=−1 gives x=1023, within_screen=0.
- write_dxy (dx0=−3) on a tick cycle with old dx=2: the step uses +2; the following step uses −3.
- rst asserted mid-motion (x=300): next cycle x=0, y=0, step=0, within_screen=1, counter restarts; no step until 4 cycles after enable.
